// File: rtl/mod_exp_arbiter_if.sv
// Bundles the requester, response and engine signals around one shared mod_exp engine.
// slave = the arbiter's view; master = requesters plus engine (the environment).
interface mod_exp_arbiter_if #(
    parameter int K    = 196,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*K-1:0] req_x;
    logic [NREQ*K-1:0] req_y;

    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [K-1:0]      rsp_z;
    logic              rsp_err;

    logic [K-1:0]      eng_x;
    logic [K-1:0]      eng_y;
    logic              eng_start;
    logic              eng_rst;
    logic [K-1:0]      eng_z;
    logic              eng_done;

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready, eng_z, eng_done,
        output req_ready, rsp_valid, rsp_z, rsp_err, eng_x, eng_y, eng_start, eng_rst
    );

    modport master (
        output req_valid, req_x, req_y, rsp_ready, eng_z, eng_done,
        input  req_ready, rsp_valid, rsp_z, rsp_err, eng_x, eng_y, eng_start, eng_rst
    );
endinterface

// File: rtl/mod_exp_arbiter.sv
// Round-robin arbiter sharing one mod_exp engine between NREQ requesters.
// Optional busy watchdog enabled by defining MODEXP_WDOG_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants round-robin from last+1
// ISSUE | operands latched, eng_start pulsed
// BUSY  | waiting for eng_done (or watchdog expiry)
// RESP  | result presented to cur_id until its rsp_ready
module mod_exp_arbiter #(
    parameter int K        = 196,
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int WDOG_CYC = 200000
) (
    input  logic             clk,
    input  logic             rst,
    mod_exp_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] scan_id;
    logic           grant_ok;
    logic           rsp_hs;
    logic           wdog_abort;
    logic [K-1:0]   x_q;
    logic [K-1:0]   y_q;
    logic [K-1:0]   z_q;
    logic           err_q;
    int             scan_idx;

    // First valid requester at or after last+1, wrapping.
    always_comb begin
        grant_ok = 1'b0;
        grant_id = '0;
        scan_idx = 0;
        scan_id  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            scan_idx = (int'(last) + off) % NREQ;
            scan_id  = IDW'(scan_idx);
            if (!grant_ok && bus.req_valid[scan_id]) begin
                grant_ok = 1'b1;
                grant_id = scan_id;
            end
        end
    end

    assign rsp_hs = bus.rsp_ready[cur_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ok) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (bus.eng_done || wdog_abort) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last   <= IDW'(NREQ - 1);
            cur_id <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        cur_id <= grant_id;
                        x_q    <= bus.req_x[int'(grant_id)*K +: K];
                        y_q    <= bus.req_y[int'(grant_id)*K +: K];
                    end
                end
                BUSY: begin
                    // A genuine done in the expiry cycle still wins over the abort.
                    if (bus.eng_done) begin
                        z_q   <= bus.eng_z;
                        err_q <= 1'b0;
                    end else if (wdog_abort) begin
                        z_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) last <= cur_id;
                end
                default: ;
            endcase
        end
    end

`ifdef MODEXP_WDOG_EN
    localparam int WDW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

    logic [WDW-1:0] wdog_cnt;
    logic           abort_q;

    // Loaded while in ISSUE so the first BUSY cycle sees WDOG_CYC-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= wdog_abort;
            if (state == ISSUE) begin
                wdog_cnt <= WDW'(WDOG_CYC - 1);
            end else if (state == BUSY && wdog_cnt != '0) begin
                wdog_cnt <= wdog_cnt - WDW'(1);
            end
        end
    end

    assign wdog_abort  = (state == BUSY) && !bus.eng_done && (wdog_cnt == '0);
    assign bus.eng_rst = rst | abort_q;
`else
    assign wdog_abort  = 1'b0;
    assign bus.eng_rst = rst;
`endif

    // Outputs are forced quiet in the reset cycle itself, not only after the edge.
    assign bus.req_ready = (!rst && state == IDLE && grant_ok) ? (NREQ'(1) << grant_id) : '0;
    assign bus.rsp_valid = (!rst && state == RESP) ? (NREQ'(1) << cur_id) : '0;
    assign bus.eng_start = !rst && (state == ISSUE);
    assign bus.eng_x     = rst ? '0 : x_q;
    assign bus.eng_y     = rst ? '0 : y_q;
    assign bus.rsp_z     = rst ? '0 : z_q;
    assign bus.rsp_err   = !rst && err_q;

endmodule
